serial_word_deserializer: RTL

- Receive end of the bit-serial word transfer. The upstream sender walks an index 0..V-1 and emits one bit per cycle, LSB first, then spends one idle cycle while its index wraps.
- This block rebuilds each V-bit word in a shift/index register and holds it in a single-entry output buffer.
- It presents the buffered word to the consumer with a valid/ready handshake.
- It sits between the serial link and the lane-array logic that fans the word out, one bit per lane.

---
 rtl/serial_word_deserializer_if.sv | 15 +
 rtl/serial_word_deserializer.sv | 69 ++++++
 2 files changed

// File: rtl/serial_word_deserializer_if.sv
// serial_word_deserializer_if: serial bit link in, buffered word out with valid/ready.
// SERIAL_DESER_PARITY_EN adds the sticky o_parity_err flag.
interface serial_word_deserializer_if #(parameter int V = 8);
  logic i_bit, i_bit_valid, i_ready;
  logic [V-1:0] o_word;
  logic o_valid, o_busy, o_overrun;
`ifdef SERIAL_DESER_PARITY_EN
  logic o_parity_err;
  modport master(output i_bit, i_bit_valid, i_ready, input o_word, o_valid, o_busy, o_overrun, o_parity_err);
  modport slave(input i_bit, i_bit_valid, i_ready, output o_word, o_valid, o_busy, o_overrun, o_parity_err);
`else
  modport master(output i_bit, i_bit_valid, i_ready, input o_word, o_valid, o_busy, o_overrun);
  modport slave(input i_bit, i_bit_valid, i_ready, output o_word, o_valid, o_busy, o_overrun);
`endif
endinterface

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: rebuilds LSB-first serial words into a one-entry valid/ready buffer.
// SERIAL_DESER_PARITY_EN: an even-parity bit follows each word; bad words are dropped and flagged.
module serial_word_deserializer #(parameter int V = 8) (
  input logic i_clk,
  input logic i_arst,
  serial_word_deserializer_if.slave bus
);
  localparam int IW = $clog2(V + 1);
`ifdef SERIAL_DESER_PARITY_EN
  localparam logic [IW-1:0] LAST = IW'(V);
`else
  localparam logic [IW-1:0] LAST = IW'(V - 1);
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [V-1:0] shift, merged, word_in, word_q;
  logic valid_q, overrun_q, done, ok, load;
  // bits above idx are still zero, so OR-ing places the incoming bit
  assign merged = shift | (V'(bus.i_bit) << idx);
`ifdef SERIAL_DESER_PARITY_EN
  logic perr_q;
  assign ok = bus.i_bit == ^shift;
  assign word_in = shift;
  assign bus.o_parity_err = perr_q;
`else
  assign ok = 1'b1;
  assign word_in = merged;
`endif
  assign done = state == SHIFT && bus.i_bit_valid && idx == LAST;
  assign load = done && ok && (!valid_q || bus.i_ready);
  assign bus.o_busy = state != IDLE;
  assign bus.o_word = word_q;
  assign bus.o_valid = valid_q;
  assign bus.o_overrun = overrun_q;
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state <= IDLE;
      idx <= '0;
      shift <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.i_bit_valid) begin
          shift <= V'(bus.i_bit);
          idx <= IW'(1);
          state <= SHIFT;
        end
        SHIFT: if (bus.i_bit_valid) begin
          shift <= merged;
          idx <= done ? '0 : idx + 1'b1;
          state <= done ? GAP : SHIFT;
        end
        default: state <= IDLE;
      endcase
      if (load) word_q <= word_in;
      valid_q <= load | (valid_q & ~bus.i_ready);
      if (done && ok && valid_q && !bus.i_ready) overrun_q <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
      if (done && !ok) perr_q <= 1'b1;
`endif
    end
  end
endmodule
